instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 102 ++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, reads instruction memory
// on request and hands the returned word to the instruction register.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_val,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  ld_ir,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  busy,
  output logic                  fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // Count value seen during the last READ cycle the unit is willing to wait.
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DELIVER
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a hold-value default first, so no
  // path through the case statement can leave a signal unassigned (no latch).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        // A jump and a fetch together read from the jump target.
        if (pc_load) pc_d = pc_load_val;
        if (fetch_req) begin
          state_d = READ;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      READ: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          state_d = DELIVER;
        end else if (cnt_q == LAST_WAIT) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd    = (state_q == READ);
  assign ld_ir     = (state_q == DELIVER);
  assign busy      = (state_q != IDLE);
  assign mem_addr  = pc_q;
  assign pc_out    = pc_q;
  assign ir_data   = ir_q;
  assign fetch_err = err_q;

endmodule
